uart_rx32: RTL and testbench

Serial receiver for the 8N1 stream produced by the team's UART transmit path. It oversamples `rx` on a single system clock, deserialises bytes LSB-first, and packs four consecutive bytes into a 32-bit word. The first byte received lands in `[31:24]`, matching the transmit side's MSB-byte-first order. The word is offered on a valid/ready port to the memory-mapped peripheral wrapper, with sticky error flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx.sv | 108 ++++++++++
 rtl/uart_rx32.sv | 113 +++++++++++
 tb/tb_uart_rx32.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Definitions shared by the UART receive path: the byte-FSM state type
// and the frame/word geometry used by uart_rx and uart_rx32.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
// Single 8N1 byte receiver: 2-flop synchroniser on rx followed by the
// byte FSM that samples every bit near its centre.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   rx_byte    last received byte (valid while byte_done is high)
//   byte_done  1-cycle pulse: byte with good stop bit received
//   stop_err   1-cycle pulse: stop bit sampled low
//   busy       FSM is not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      byte_done,
  output logic                      stop_err,
  output logic                      busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic                      rx_meta, rx_s;
  uart_state_t               state, state_n;
  logic [CW-1:0]             clk_cnt, clk_cnt_n;
  logic [BW-1:0]             bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] sh, sh_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      sh      <= sh_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + CW'(1);
    bit_idx_n = bit_idx;
    sh_n      = sh;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high line means a glitch.
        if (clk_cnt == HALF_M1) begin
          clk_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          sh_n      = {rx_s, sh[UART_DATA_BITS-1:1]};
          bit_idx_n = bit_idx + BW'(1);
          if (bit_idx == LAST_BIT) state_n = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit gives half a bit to catch the next start edge.
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            stop_err  = 1'b1;
            state_n   = BREAK;
          end
        end
      end
      BREAK: begin
        clk_cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_byte = sh;
  assign busy    = (state != IDLE);

endmodule

// File: rtl/uart_rx32.sv
`timescale 1ns/1ps
// uart_rx32
// UART receiver that packs four bytes (first byte in [31:24]) into a
// 32-bit word offered on a valid/ready port, with sticky error flags and
// an idle timeout that discards partially assembled words.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   rdata         assembled word
//   rdata_valid   rdata holds an unconsumed word
//   rdata_ready   consumer accepts rdata this cycle
//   overrun       sticky: a completed word was dropped
//   frame_err     sticky: a stop bit sampled low
//   err_clear     clears overrun and frame_err (a new error wins)
//   busy          byte FSM not in IDLE
module uart_rx32
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic        overrun,
  output logic        frame_err,
  input  logic        err_clear,
  output logic        busy
);

  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);
  localparam int unsigned NW       = $clog2(UART_WORD_BYTES);
  localparam int unsigned PW       = (UART_WORD_BYTES - 1) * UART_DATA_BITS;
  localparam logic [TW-1:0] TO_M1     = TW'(TO_LIMIT - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TO_LIMIT);
  localparam logic [NW-1:0] LAST_BYTE = NW'(UART_WORD_BYTES - 1);

  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      byte_done, stop_err;
  logic [PW-1:0]             word;
  logic [NW-1:0]             cnt;
  logic [TW-1:0]             idle_cnt;
  logic                      word_done, slot_free, timeout;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .stop_err (stop_err),
    .busy     (busy)
  );

  always_comb begin
    word_done = byte_done && (cnt == LAST_BYTE);
    // The slot can take a new word if empty or being drained this cycle.
    slot_free = !rdata_valid || rdata_ready;
    timeout   = (idle_cnt == TO_M1) && (cnt != '0) && !busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      word        <= '0;
      cnt         <= '0;
      idle_cnt    <= '0;
    end else begin
      if (word_done && slot_free) begin
        rdata       <= {word, rx_byte};
        rdata_valid <= 1'b1;
      end else if (rdata_ready) begin
        rdata_valid <= 1'b0;
      end

      if (stop_err) begin
        cnt <= '0;
      end else if (byte_done) begin
        if (word_done) begin
          cnt <= '0;
        end else begin
          cnt  <= cnt + NW'(1);
          word <= {word[PW-UART_DATA_BITS-1:0], rx_byte};
        end
      end else if (timeout) begin
        cnt <= '0;
      end

      // Any activity on the line (FSM leaves IDLE) restarts the idle count.
      if (busy || (cnt == '0)) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_MAX) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (word_done && !slot_free) overrun <= 1'b1;
      else if (err_clear)          overrun <= 1'b0;

      if (stop_err)       frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx32.sv
`timescale 1ns/1ps
module tb_uart_rx32;

  localparam int unsigned CPB = 16;
  localparam int unsigned TOB = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic        overrun;
  logic        frame_err;
  logic        err_clear;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  uart_rx32 #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .err_clear  (err_clear),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every accepted word is compared against the queue.
  always @(negedge clk) begin
    if (!rst && rdata_valid && rdata_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h required none", rdata);
      end else begin
        check("scoreboard_word", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask

  // Last byte is driven by hand so the load cycle (mid stop bit) can be probed.
  task automatic send_word(input logic [31:0] w, input bit pulse_ready, input bit chk_timing);
    for (int i = 0; i < 3; i++) send_byte(w[31-8*i -: 8], 1'b1);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(w[i]);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if (pulse_ready) rdata_ready = 1'b1;
    @(negedge clk);
    if (chk_timing) check("valid_before_stop_sample", rdata_valid, 0);
    @(posedge clk);
    #1;
    rdata_ready = 1'b0;
    if (chk_timing) check("valid_after_stop_sample", rdata_valid, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic consume(input string name);
    int k = 0;
    while (!rdata_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!rdata_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: rdata_valid got 0 required 1", name);
    end else begin
      @(posedge clk);
      #1;
      rdata_ready = 1'b1;
      @(posedge clk);
      #1;
      rdata_ready = 1'b0;
      check({name, "_valid_clear"}, rdata_valid, 0);
    end
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rdata_ready = 1'b0; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_valid", rdata_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);

    // Nominal word, ready held low until after load.
    exp_q.push_back(32'h68656C6F);
    send_word(32'h68656C6F, 1'b0, 1'b1);
    check("nominal_rdata", rdata, 32'h68656C6F);
    repeat (3) @(posedge clk);
    #1;
    check("nominal_valid_held", rdata_valid, 1);
    consume("nominal");

    // Glitch rejection.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("glitch_busy", busy, 0);
    check("glitch_valid", rdata_valid, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overrun", overrun, 0);
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    consume("glitch_word");

    // Framing error aborts the partial word.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    check("frame_err_set", frame_err, 1);
    exp_q.push_back(32'hAABBCCDD);
    send_word(32'hAABBCCDD, 1'b0, 1'b0);
    check("frame_rdata", rdata, 32'hAABBCCDD);
    consume("frame_word");
    pulse_clear();
    check("frame_err_cleared", frame_err, 0);

    // Overrun: second word dropped while the first is unconsumed.
    exp_q.push_back(32'h11223344);
    send_word(32'h11223344, 1'b0, 1'b0);
    send_word(32'h55667788, 1'b0, 1'b0);
    check("overrun_set", overrun, 1);
    check("overrun_rdata_held", rdata, 32'h11223344);
    consume("overrun_first");
    pulse_clear();
    check("overrun_cleared", overrun, 0);

    // Load and consume in the same cycle.
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    exp_q.push_back(32'h13579BDF);
    send_word(32'h13579BDF, 1'b1, 1'b0);
    check("simul_valid", rdata_valid, 1);
    check("simul_rdata", rdata, 32'h13579BDF);
    check("simul_overrun", overrun, 0);
    consume("simul_second");

    // Idle timeout discards a partial word.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (33 * CPB) @(posedge clk);
    #1;
    check("timeout_no_valid", rdata_valid, 0);
    exp_q.push_back(32'h0A0B0C0D);
    send_word(32'h0A0B0C0D, 1'b0, 1'b0);
    check("timeout_rdata", rdata, 32'h0A0B0C0D);
    consume("timeout_word");

    // Reset during the data bits of the second byte.
    send_byte(8'h55, 1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_valid", rdata_valid, 0);
    check("midreset_overrun", overrun, 0);
    check("midreset_frame_err", frame_err, 0);
    check("midreset_busy", busy, 0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    exp_q.push_back(32'hC0FFEE42);
    send_word(32'hC0FFEE42, 1'b0, 1'b0);
    check("midreset_word", rdata, 32'hC0FFEE42);
    consume("midreset_word");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
